parking_occupancy_ctrl: RTL and testbench
=========================================

// Module: parking_occupancy_ctrl
// PURPOSE
//   Shares one occupancy up/down counter among N_LANES car-direction detectors.
//   Each lane supplies single-cycle add (S) / subtract (R) pulses. Every
//   lane/direction pair has its own small pending-event buffer.
//   A round-robin arbiter applies one event per cycle to the counter.
//   Drives the "full" sign, the "empty" status and sticky error flags for the display/gate logic.
// PARAMETERS
//   N_LANES   2   number of lane detectors (1..8)
//   CAPACITY  99  maximum number of parked cars (count saturates here)
//   CNT_W     7   width of count; must satisfy 2**CNT_W > CAPACITY
//   PEND_MAX  3   max buffered events per lane/direction (saturating)
// PORTS
//   clk       in   1        system clock, rising edge
//   rst_n     in   1        asynchronous active-low reset
//   clr       in   1        synchronous clear (operator reset of the count)
//   inc_evt   in   N_LANES  per-lane S pulse: one car entered (1 cycle wide)
//   dec_evt   in   N_LANES  per-lane R pulse: one car left (1 cycle wide)
//   count     out  CNT_W    current occupancy, registered
//   full      out  1        count == CAPACITY (decoded from count register)
//   empty     out  1        count == 0 (decoded from count register)
//   busy      out  1        any pending buffer non-zero (registered state)
//   err_ovf   out  1        sticky: an entry was applied while full
//   err_unf   out  1        sticky: an exit was applied while empty
//   lost_evt  out  1        registered 1-cycle pulse: a pulse hit a saturated buffer
// BEHAVIOUR
// - Reset (rst_n=0, async): count=0, all pending=0, rr pointer=0,
//   err_ovf=err_unf=lost_evt=0, so empty=1, full=0, busy=0.
// - Sources: 2*N_LANES requesters indexed inc0,dec0,inc1,dec1,...
//   - A source requests when its pending buffer is > 0.
// - Each edge, a source's pending value updates as pend + pulse - granted:
//   - pulse and grant in the same cycle leave the value unchanged.
//   - pulse while pend==PEND_MAX and not granted: pulse dropped, lost_evt=1 next cycle.
// - Arbiter is combinational on the pending registers and issues at most one grant per cycle.
//   - It searches from rr pointer upward, wrapping at 2*N_LANES.
//   - On a grant, the pointer becomes (granted index+1) mod 2*N_LANES; with no grant it holds.
// - Counter update on the edge where the grant is taken:
//   - inc grant, count<CAPACITY: count+1.
//   - inc grant, count==CAPACITY: count unchanged, event consumed, err_ovf<=1.
//   - dec grant, count>0: count-1.
//   - dec grant, count==0: count unchanged, event consumed, err_unf<=1.
// - Latency: a pulse sampled at edge k appears in pending after edge k.
//   With no contention it is granted in cycle k..k+1 and count changes at edge k+1,
//   i.e. 2 edges from pulse-high to new count.
// - clr=1: count, pending, pointer, err_ovf, err_unf and lost_evt all return to 0
//   at the next edge. Pulses and grants in that cycle are discarded; clr has
//   priority over all events.
// - Worst-case service: a requesting source waits at most 2*N_LANES-1 cycles.
// - Counter arithmetic is CNT_W bits wide and never wraps (saturation rules above).
// - No combinational path exists from inputs to outputs.
// TESTING
// T1 After reset, pulse inc_evt[0] for 1 cycle -> count 0->1 two edges later;
//    busy high for 1 cycle; full=0, empty 1->0.
// T2 inc_evt=2'b11 in one cycle with pointer=0 -> inc0 is granted first, then inc1;
//    count reads 1, then 2, on consecutive edges.
// T3 Preload count=99, then pulse inc_evt[1] -> count stays 99, full=1, err_ovf=1
//    and stays 1 until clr.
// T4 count=0, pulse dec_evt[0] -> count stays 0, err_unf=1, empty=1.
// T5 Hold inc0 pending while inc1 and dec1 are continuously fed: pulse inc_evt[0]
//    4 times in 4 consecutive cycles -> 3 buffered, one lost_evt pulse, count +3 net.
// T6 Assert rst_n=0 mid-stream with pending events -> all outputs zero/empty=1
//    immediately; after release no stale event is applied. Repeat with clr.

Source files
------------

// File: rtl/parking_occupancy_ctrl_if.sv
// ----------------------------------------------------------------------------
// parking_occupancy_ctrl_if
//   Groups the lane-event inputs and the occupancy/status outputs of
//   parking_occupancy_ctrl.
//   master : event source / display side (drives clr, inc_evt, dec_evt)
//   slave  : the occupancy controller (drives count and status flags)
// ----------------------------------------------------------------------------
interface parking_occupancy_ctrl_if #(
   parameter int N_LANES = 2,
   parameter int CNT_W   = 7
);
   logic               clr;
   logic [N_LANES-1:0] inc_evt;
   logic [N_LANES-1:0] dec_evt;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               empty;
   logic               busy;
   logic               err_ovf;
   logic               err_unf;
   logic               lost_evt;

   modport master (
      output clr, inc_evt, dec_evt,
      input  count, full, empty, busy, err_ovf, err_unf, lost_evt
   );

   modport slave (
      input  clr, inc_evt, dec_evt,
      output count, full, empty, busy, err_ovf, err_unf, lost_evt
   );
endinterface

// File: rtl/parking_occupancy_ctrl.sv
// ----------------------------------------------------------------------------
// parking_occupancy_ctrl
//   One occupancy up/down counter shared by N_LANES entry/exit detectors.
//   Every lane/direction has a saturating pending-event buffer; a round-robin
//   arbiter applies one buffered event per cycle to the counter.
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : slave side of parking_occupancy_ctrl_if
//     clr       sync clear of count, buffers, pointer and flags
//     inc_evt   per-lane 1-cycle "car entered" pulse
//     dec_evt   per-lane 1-cycle "car left" pulse
//     count     registered occupancy
//     full      count == CAPACITY
//     empty     count == 0
//     busy      some pending buffer is non-zero
//     err_ovf   sticky: entry applied while full
//     err_unf   sticky: exit applied while empty
//     lost_evt  1-cycle pulse: a pulse hit a saturated buffer
// ----------------------------------------------------------------------------
module parking_occupancy_ctrl #(
   parameter int N_LANES  = 2,
   parameter int CAPACITY = 99,
   parameter int CNT_W    = 7,
   parameter int PEND_MAX = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   parking_occupancy_ctrl_if.slave  bus
);
   // Sources are interleaved inc0,dec0,inc1,dec1,... so bit 0 of a source
   // index tells the direction.
   localparam int N_SRC = 2 * N_LANES;
   localparam int PW    = $clog2(PEND_MAX + 1);
   localparam int PTR_W = $clog2(N_SRC);

   localparam logic [PW-1:0]    PEND_FULL = PW'(PEND_MAX);
   localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACITY);
   localparam logic [PTR_W-1:0] LAST_SRC  = PTR_W'(N_SRC - 1);

   logic [N_SRC-1:0][PW-1:0] pend_q, pend_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic                     err_ovf_q, err_ovf_d;
   logic                     err_unf_q, err_unf_d;
   logic                     lost_q, lost_d;

   logic [N_SRC-1:0]         pulse;
   logic [N_SRC-1:0]         req;
   logic [N_SRC-1:0]         gnt;
   logic                     gnt_vld;
   logic [PTR_W-1:0]         gnt_idx;

   // Flatten lane pulses into the interleaved source order.
   always_comb begin
      pulse = '0;
      req   = '0;
      for (int i = 0; i < N_LANES; i++) begin
         pulse[2*i]   = bus.inc_evt[i];
         pulse[2*i+1] = bus.dec_evt[i];
      end
      for (int s = 0; s < N_SRC; s++) begin
         req[s] = (pend_q[s] != '0);
      end
   end

   // Round-robin: first requester at or above the pointer, wrapping.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int off = 0; off < N_SRC; off++) begin
         idx = (int'(ptr_q) + off) % N_SRC;
         if (!gnt_vld && req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = PTR_W'(idx);
         end
      end
      gnt = '0;
      if (gnt_vld) gnt[gnt_idx] = 1'b1;
   end

   always_comb begin
      pend_d    = pend_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      err_ovf_d = err_ovf_q;
      err_unf_d = err_unf_q;
      lost_d    = 1'b0;

      // pend + pulse - grant, saturating at PEND_MAX (overflow is dropped).
      for (int s = 0; s < N_SRC; s++) begin
         if (pulse[s] && !gnt[s]) begin
            if (pend_q[s] == PEND_FULL) lost_d = 1'b1;
            else                        pend_d[s] = pend_q[s] + 1'b1;
         end else if (!pulse[s] && gnt[s]) begin
            pend_d[s] = pend_q[s] - 1'b1;
         end
      end

      if (gnt_vld) begin
         ptr_d = (gnt_idx == LAST_SRC) ? '0 : gnt_idx + 1'b1;
         if (!gnt_idx[0]) begin
            // Entry: saturate at capacity, flag the impossible event.
            if (count_q == CAP_V) err_ovf_d = 1'b1;
            else                  count_d   = count_q + 1'b1;
         end else begin
            if (count_q == '0) err_unf_d = 1'b1;
            else               count_d   = count_q - 1'b1;
         end
      end

      // Operator clear beats every event in the same cycle.
      if (bus.clr) begin
         pend_d    = '0;
         ptr_d     = '0;
         count_d   = '0;
         err_ovf_d = 1'b0;
         err_unf_d = 1'b0;
         lost_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q    <= '0;
         ptr_q     <= '0;
         count_q   <= '0;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
         lost_q    <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
         lost_q    <= lost_d;
      end
   end

   // All outputs decode registers only.
   assign bus.count    = count_q;
   assign bus.full     = (count_q == CAP_V);
   assign bus.empty    = (count_q == '0);
   assign bus.busy     = |req;
   assign bus.err_ovf  = err_ovf_q;
   assign bus.err_unf  = err_unf_q;
   assign bus.lost_evt = lost_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
module tb_parking_occupancy_ctrl;
   localparam int N   = 2;
   localparam int CAP = 99;
   localparam int CW  = 7;
   localparam int PM  = 3;
   localparam int NS  = 2 * N;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   parking_occupancy_ctrl_if #(.N_LANES(N), .CNT_W(CW)) bus ();

   parking_occupancy_ctrl #(
      .N_LANES(N), .CAPACITY(CAP), .CNT_W(CW), .PEND_MAX(PM)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Event-count view: how many events each source still owes, whose turn
   // it is, and the resulting occupancy.
   typedef struct packed {
      logic [NS-1:0][7:0] pend;
      logic [7:0]         ptr;
      logic [7:0]         cnt;
      logic               ovf;
      logic               unf;
      logic               lost;
   } mstate_t;

   mstate_t m = '0;

   function automatic mstate_t model_next(mstate_t s, logic [N-1:0] inc, logic [N-1:0] dec);
      mstate_t n;
      int win;
      int p;
      int idx;
      n      = s;
      n.lost = 1'b0;
      win    = -1;
      for (int off = 0; off < NS; off++) begin
         idx = (int'(s.ptr) + off) % NS;
         if (win < 0 && s.pend[idx] != 8'd0) win = idx;
      end
      if (win >= 0) begin
         n.ptr = 8'((win + 1) % NS);
         if (win % 2 == 0) begin
            if (int'(s.cnt) == CAP) n.ovf = 1'b1;
            else                    n.cnt = s.cnt + 8'd1;
         end else begin
            if (s.cnt == 8'd0) n.unf = 1'b1;
            else               n.cnt = s.cnt - 8'd1;
         end
      end
      for (int src = 0; src < NS; src++) begin
         p = int'(s.pend[src]);
         if ((src % 2 == 0) ? inc[src/2] : dec[src/2]) p = p + 1;
         if (src == win) p = p - 1;
         if (p > PM) begin
            p      = PM;
            n.lost = 1'b1;
         end
         n.pend[src] = 8'(p);
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)       m <= '0;
      else if (bus.clr) m <= '0;
      else              m <= model_next(m, bus.inc_evt, bus.dec_evt);
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      check("m_count",  32'(bus.count),    32'(m.cnt));
      check("m_full",   32'(bus.full),     32'(int'(m.cnt) == CAP));
      check("m_empty",  32'(bus.empty),    32'(m.cnt == 8'd0));
      check("m_busy",   32'(bus.busy),     32'(m.pend != '0));
      check("m_ovf",    32'(bus.err_ovf),  32'(m.ovf));
      check("m_unf",    32'(bus.err_unf),  32'(m.unf));
      check("m_lost",   32'(bus.lost_evt), 32'(m.lost));
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic [N-1:0] inc, input logic [N-1:0] dec, input logic c);
      @(negedge clk);
      bus.inc_evt = inc;
      bus.dec_evt = dec;
      bus.clr     = c;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, 2'b00, 1'b0);
   endtask

   initial begin
      bus.clr     = 1'b0;
      bus.inc_evt = '0;
      bus.dec_evt = '0;
      rst_n       = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_count", 32'(bus.count), 0);
      check("rst_empty", 32'(bus.empty), 1);
      check("rst_full",  32'(bus.full),  0);
      check("rst_busy",  32'(bus.busy),  0);
      check("rst_flags", {29'd0, bus.err_ovf, bus.err_unf, bus.lost_evt}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // T1: single entry, two edges to the new count
      step(2'b01, 2'b00, 1'b0);
      check("t1_count0", 32'(bus.count), 0);
      check("t1_busy",   32'(bus.busy),  1);
      check("t1_empty0", 32'(bus.empty), 1);
      step(2'b00, 2'b00, 1'b0);
      check("t1_count1", 32'(bus.count), 1);
      check("t1_busy0",  32'(bus.busy),  0);
      check("t1_empty1", 32'(bus.empty), 0);
      check("t1_full",   32'(bus.full),  0);

      // T2: simultaneous entries with pointer at 0
      step(2'b00, 2'b00, 1'b1);
      check("t2_clr", 32'(bus.count), 0);
      step(2'b11, 2'b00, 1'b0);
      step(2'b00, 2'b00, 1'b0);
      check("t2_first",  32'(bus.count), 1);
      step(2'b00, 2'b00, 1'b0);
      check("t2_second", 32'(bus.count), 2);
      check("t2_busy",   32'(bus.busy),  0);

      // T3: fill to capacity, then one more entry
      step(2'b00, 2'b00, 1'b1);
      for (int i = 0; i < CAP; i++) step(2'b01, 2'b00, 1'b0);
      idle(2);
      check("t3_cap",  32'(bus.count), CAP);
      check("t3_full", 32'(bus.full),  1);
      step(2'b10, 2'b00, 1'b0);
      step(2'b00, 2'b00, 1'b0);
      check("t3_hold", 32'(bus.count),   CAP);
      check("t3_ovf",  32'(bus.err_ovf), 1);
      idle(3);
      check("t3_sticky", 32'(bus.err_ovf), 1);
      step(2'b00, 2'b00, 1'b1);
      check("t3_clr_ovf",   32'(bus.err_ovf), 0);
      check("t3_clr_count", 32'(bus.count),   0);

      // T4: exit while empty
      step(2'b00, 2'b01, 1'b0);
      step(2'b00, 2'b00, 1'b0);
      check("t4_count", 32'(bus.count),   0);
      check("t4_unf",   32'(bus.err_unf), 1);
      check("t4_empty", 32'(bus.empty),   1);
      step(2'b00, 2'b00, 1'b1);
      check("t4_clr_unf", 32'(bus.err_unf), 0);

      // T5: preload 5 (pointer ends at 1), then all four sources fed for
      // 4 cycles; inc0 waits behind dec0, inc1, dec1 and its 4th pulse drops.
      for (int i = 0; i < 5; i++) step(2'b01, 2'b00, 1'b0);
      idle(2);
      check("t5_pre", 32'(bus.count), 5);
      for (int i = 0; i < 3; i++) step(2'b11, 2'b11, 1'b0);
      step(2'b11, 2'b11, 1'b0);
      check("t5_lost",  32'(bus.lost_evt), 1);
      check("t5_cnt_e", 32'(bus.count),    4);
      step(2'b00, 2'b00, 1'b0);
      check("t5_lost0", 32'(bus.lost_evt), 0);
      check("t5_cnt_f", 32'(bus.count),    5);
      idle(14);
      check("t5_final", 32'(bus.count), 4);
      check("t5_idle",  32'(bus.busy),  0);

      // T6a: async reset in the middle of a burst
      step(2'b11, 2'b00, 1'b0);
      step(2'b11, 2'b00, 1'b0);
      @(negedge clk);
      bus.inc_evt = '0;
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_count", 32'(bus.count), 0);
      check("t6_rst_empty", 32'(bus.empty), 1);
      check("t6_rst_busy",  32'(bus.busy),  0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      check("t6_no_stale", 32'(bus.count), 0);

      // T6b: clr with pending events and pulses in the same cycle
      for (int i = 0; i < 3; i++) step(2'b01, 2'b00, 1'b0);
      check("t6_pre_clr", 32'(bus.count), 2);
      step(2'b11, 2'b11, 1'b1);
      check("t6_clr_count", 32'(bus.count), 0);
      check("t6_clr_busy",  32'(bus.busy),  0);
      idle(3);
      check("t6_clr_stale", 32'(bus.count), 0);
      check("t6_clr_idle",  32'(bus.busy),  0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
